multicycle_maindec: RTL and testbench
=====================================

// Module: multicycle_maindec
// PURPOSE
//  Main control FSM for the multicycle RV32I/RV64I datapath. Successor to the single-cycle main decoder.
//  Sequences FETCH/DECODE/EXECUTE/MEM/WB per instruction from op/funct3 held in the IR.
//  Drives datapath muxes, IR/PC/register/memory write strobes and address-aligned byte enables.
//  Flags illegal and misaligned instructions instead of emitting X.
// PARAMETERS
//  XLEN   32  datapath width, 32 or 64; byte-enable width NB = XLEN/8
//  ABW    $clog2(XLEN/8)  width of address low bits used for lane selection
// PORTS
//  clk           in   1    clock
//  reset         in   1    asynchronous, active-high reset
//  op            in   7    IR[6:0]
//  funct3        in   3    IR[14:12]
//  addr_lo       in   ABW  ALUResult[ABW-1:0] (effective address low bits)
//  branch_taken  in   1    branch condition from ALU flags
//  mem_ready     in   1    memory ack (used only with MEM_STALL_EN)
//  pc_write      out  1    pc_update | (branch & branch_taken)
//  adr_src       out  1    0 = PC, 1 = ALUOut as memory address
//  ir_write      out  1    latch instruction and OldPC
//  mem_write     out  1    store strobe
//  byte_en       out  NB   store lane enables
//  reg_write     out  1    register-file write
//  result_src    out  2    00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt
//  alu_src_a     out  2    00 PC, 01 OldPC, 10 rs1
//  alu_src_b     out  2    00 rs2, 01 ImmExt, 10 constant 4
//  alu_op        out  2    00 add, 01 sub/branch, 10 funct-decoded
//  imm_src       out  3    000 I, 001 S, 010 B, 011 J, 100 U
//  illegal_instr out  1    one-cycle pulse in ILLEGAL state
//  misaligned    out  1    one-cycle pulse: misaligned store detected
// BEHAVIOUR
//  One clock; reset is asynchronous and active-high.
//  Reset: state = FETCH at once, mid-instruction included; no partial writeback afterwards.
//  Moore outputs from the registered state, except byte_en, misaligned, pc_write and the
//  MEMWRITE mem_write (these also use inputs).
//  Reset/FETCH output values: ir_write=1, pc_write=1, alu_src_a=00, alu_src_b=10, alu_op=00,
//  result_src=10, imm_src=000, adr_src=0. All other outputs are 0.
//  Unlisted outputs in every state are 0; imm_src follows op in all states.
//  FETCH -> DECODE.
//  DECODE (alu_src_a=01, alu_src_b=01, alu_op=00) branches on op:
//    03 -> MEMADR; 23 -> MEMADR; 33 -> EXECR; 13 -> EXECI; 63 -> BEQ; 6F -> JAL;
//    67 -> JALR1; 37 -> LUI; 17 -> AUIPC; any other op -> ILLEGAL.
//  MEMADR (a=10, b=01, add): load -> MEMREAD; store -> MEMWRITE.
//    Store funct3 must be 000/001/010 (also 011 when XLEN=64); otherwise -> ILLEGAL.
//  MEMREAD (adr_src=1) -> MEMWB (result_src=01, reg_write) -> FETCH.
//  MEMWRITE (adr_src=1) -> FETCH.
//    size = 1<<funct3 bytes; byte_en = ((1<<size)-1) << addr_lo.
//    If addr_lo % size != 0: mem_write=0, byte_en=0, misaligned=1.
//  EXECR (a=10, b=00, alu_op=10) / EXECI (a=10, b=01, alu_op=10) -> ALUWB (result_src=00, reg_write) -> FETCH.
//  BEQ (a=10, b=00, alu_op=01, result_src=00, branch) -> FETCH.
//  JAL (a=01, b=10, result_src=00, pc_update) -> ALUWB.
//  JALR1 (a=10, b=01) -> JALR2 (a=01, b=10, result_src=00, pc_update) -> ALUWB.
//  LUI (result_src=11, reg_write) -> FETCH.
//  AUIPC (a=01, b=01, add) -> ALUWB.
//  ILLEGAL (illegal_instr=1) -> FETCH; no register or memory write.
//  Cycles without stall: R/I/JAL/AUIPC 4, load 5, store 4, branch 3, LUI 3, JALR 5.
// CONFIGURATION
//  MEM_STALL_EN defined: FETCH, MEMREAD and MEMWRITE hold while mem_ready=0.
//    While holding: ir_write, pc_update and reg_write are forced to 0; mem_write and byte_en are held.
//    The state advances in the cycle mem_ready=1.
//  MEM_STALL_EN undefined: mem_ready is ignored; each memory state lasts exactly 1 cycle.
// TESTING
//  1. reset=1 mid-MEMWRITE -> mem_write=0 immediately; after release, FETCH outputs (ir_write=1, pc_write=1).
//  2. op=33 (add) -> states FETCH, DECODE, EXECR, ALUWB; reg_write=1 only in cycle 4; back in FETCH at cycle 5.
//  3. sb with addr_lo=2 -> byte_en=0100.
//     sh with addr_lo=2 -> byte_en=1100.
//     sw with addr_lo=0 -> byte_en=1111.
//     sh with addr_lo=1 -> mem_write=0, misaligned=1.
//  4. op=63: branch_taken=1 -> pc_write=1 in BEQ; branch_taken=0 -> pc_write=0; next state is FETCH.
//  5. op=7F, or store funct3=100 -> illegal_instr pulses 1 cycle; reg_write/mem_write never set; then FETCH.
//  6. MEM_STALL_EN, lw with mem_ready=0 for 3 cycles -> stays in MEMREAD with reg_write=0.
//     Once mem_ready=1 -> MEMWB with reg_write=1.

Source files
------------

// File: rtl/multicycle_maindec.sv
// rtl/multicycle_maindec.sv - multicycle RV32I/RV64I main control FSM
// Optional MEM_STALL_EN: FETCH/MEMREAD/MEMWRITE wait for mem_ready.
module multicycle_maindec #(
  parameter int XLEN = 32,
  parameter int ABW  = $clog2(XLEN/8)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [6:0]        op,
  input  logic [2:0]        funct3,
  input  logic [ABW-1:0]    addr_lo,
  input  logic              branch_taken,
  input  logic              mem_ready,
  output logic              pc_write,
  output logic              adr_src,
  output logic              ir_write,
  output logic              mem_write,
  output logic [XLEN/8-1:0] byte_en,
  output logic              reg_write,
  output logic [1:0]        result_src,
  output logic [1:0]        alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic [1:0]        alu_op,
  output logic [2:0]        imm_src,
  output logic              illegal_instr,
  output logic              misaligned
);

  localparam int NB = XLEN/8;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_JALR1, S_JALR2,
    S_LUI, S_AUIPC, S_ILLEGAL
  } state_t;

  state_t          state_q, state_d;
  logic            mem_go;
  logic            store_f3_ok;
  logic            pc_update;
  logic            branch;
  logic [NB-1:0]   st_mask;
  logic [NB-1:0]   st_lanes;
  logic            st_misaligned;

`ifdef MEM_STALL_EN
  assign mem_go = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_go = 1'b1;
`endif

  assign store_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                       ((XLEN == 64) && (funct3 == 3'b011));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_go) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          7'h03, 7'h23: state_d = S_MEMADR;
          7'h33:        state_d = S_EXECR;
          7'h13:        state_d = S_EXECI;
          7'h63:        state_d = S_BEQ;
          7'h6F:        state_d = S_JAL;
          7'h67:        state_d = S_JALR1;
          7'h37:        state_d = S_LUI;
          7'h17:        state_d = S_AUIPC;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        if (op == 7'h03)      state_d = S_MEMREAD;
        else if (store_f3_ok) state_d = S_MEMWRITE;
        else                  state_d = S_ILLEGAL;
      end
      S_MEMREAD:  if (mem_go) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_go) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_JALR1:    state_d = S_JALR2;
      S_JALR2:    state_d = S_ALUWB;
      S_LUI:      state_d = S_FETCH;
      S_AUIPC:    state_d = S_ALUWB;
      S_ILLEGAL:  state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // Store lane mask is size-wide ones shifted up to the addressed byte.
  always_comb begin
    case (funct3[1:0])
      2'b00:   st_mask = NB'(8'h01);
      2'b01:   st_mask = NB'(8'h03);
      2'b10:   st_mask = NB'(8'h0F);
      default: st_mask = NB'(8'hFF);
    endcase
    st_lanes = st_mask << addr_lo;
    case (funct3[1:0])
      2'b00:   st_misaligned = 1'b0;
      2'b01:   st_misaligned = addr_lo[0];
      2'b10:   st_misaligned = |addr_lo[1:0];
      default: st_misaligned = |addr_lo;
    endcase
  end

  always_comb begin
    adr_src       = 1'b0;
    ir_write      = 1'b0;
    mem_write     = 1'b0;
    byte_en       = '0;
    reg_write     = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    illegal_instr = 1'b0;
    misaligned    = 1'b0;
    pc_update     = 1'b0;
    branch        = 1'b0;
    case (op)
      7'h23:        imm_src = 3'b001;
      7'h63:        imm_src = 3'b010;
      7'h6F:        imm_src = 3'b011;
      7'h37, 7'h17: imm_src = 3'b100;
      default:      imm_src = 3'b000;
    endcase
    case (state_q)
      S_FETCH: begin
        ir_write   = mem_go;
        pc_update  = mem_go;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src    = 1'b1;
        mem_write  = ~st_misaligned;
        byte_en    = st_misaligned ? '0 : st_lanes;
        misaligned = st_misaligned;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      S_ALUWB:    reg_write = 1'b1;
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
      end
      S_JAL, S_JALR2: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
      end
      S_JALR1: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_LUI: begin
        result_src = 2'b11;
        reg_write  = 1'b1;
      end
      S_AUIPC: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_ILLEGAL:  illegal_instr = 1'b1;
      default: ;
    endcase
    pc_write = pc_update | (branch & branch_taken);
  end

endmodule

// File: tb/tb_multicycle_maindec.sv
// tb/tb_multicycle_maindec.sv - directed table-driven bench for multicycle_maindec
module tb_multicycle_maindec;

  localparam int XLEN = 32;
  localparam int ABW  = 2;
  localparam int NB   = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [6:0]    op;
  logic [2:0]    funct3;
  logic [ABW-1:0] addr_lo;
  logic          branch_taken;
  logic          mem_ready;
  logic          pc_write, adr_src, ir_write, mem_write, reg_write;
  logic [NB-1:0] byte_en;
  logic [1:0]    result_src, alu_src_a, alu_src_b, alu_op;
  logic [2:0]    imm_src;
  logic          illegal_instr, misaligned;

  always #5 clk = ~clk;

  multicycle_maindec #(.XLEN(XLEN), .ABW(ABW)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .addr_lo(addr_lo),
    .branch_taken(branch_taken), .mem_ready(mem_ready), .pc_write(pc_write),
    .adr_src(adr_src), .ir_write(ir_write), .mem_write(mem_write), .byte_en(byte_en),
    .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .imm_src(imm_src),
    .illegal_instr(illegal_instr), .misaligned(misaligned)
  );

  // {ir, pcw, rw, a[2], b[2], aop[2], rs[2], adr, mw}
  localparam logic [12:0] W_FETCH  = 13'b1_1_0_00_10_00_10_0_0;
  localparam logic [12:0] W_DECODE = 13'b0_0_0_01_01_00_00_0_0;
  localparam logic [12:0] W_EXECR  = 13'b0_0_0_10_00_10_00_0_0;
  localparam logic [12:0] W_ALUWB  = 13'b0_0_1_00_00_00_00_0_0;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [1:0] a;
    logic       bt;
    int         cyc, rw, mw, pcw, ill, mis;
    logic [3:0] be;
  } vec_t;

  vec_t vecs[19];
  int compared = 0;
  int mismatched = 0;

  function automatic logic [12:0] ctrl_word();
    return {ir_write, pc_write, reg_write, alu_src_a, alu_src_b, alu_op,
            result_src, adr_src, mem_write};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [6:0] o, input logic [2:0] f, input logic [1:0] a,
                         input logic bt, input int cyc, input int rw, input int mw,
                         input int pcw, input int ill, input int mis, input logic [3:0] be);
    vecs[i].op = o;   vecs[i].f3 = f;   vecs[i].a = a;     vecs[i].bt = bt;
    vecs[i].cyc = cyc; vecs[i].rw = rw; vecs[i].mw = mw;   vecs[i].pcw = pcw;
    vecs[i].ill = ill; vecs[i].mis = mis; vecs[i].be = be;
  endtask

  // Runs one instruction from FETCH until the next FETCH, accumulating strobes.
  task automatic run_instr(input int i);
    int cyc, rw, mw, pcw, ill, mis;
    logic [3:0] be;
    op = vecs[i].op; funct3 = vecs[i].f3; addr_lo = vecs[i].a; branch_taken = vecs[i].bt;
    cyc = 0; rw = 0; mw = 0; pcw = 0; ill = 0; mis = 0; be = 4'b0;
    #1;
    do begin
      rw += int'(reg_write); mw += int'(mem_write); pcw += int'(pc_write);
      ill += int'(illegal_instr); mis += int'(misaligned); be |= byte_en;
      cyc++;
      @(negedge clk); #1;
    end while (!ir_write && cyc < 20);
    check($sformatf("v%0d_cycles", i), cyc, vecs[i].cyc);
    check($sformatf("v%0d_reg_write", i), rw, vecs[i].rw);
    check($sformatf("v%0d_mem_write", i), mw, vecs[i].mw);
    check($sformatf("v%0d_pc_write", i), pcw, vecs[i].pcw);
    check($sformatf("v%0d_illegal", i), ill, vecs[i].ill);
    check($sformatf("v%0d_misaligned", i), mis, vecs[i].mis);
    check($sformatf("v%0d_byte_en", i), {28'b0, be}, {28'b0, vecs[i].be});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [12:0] add_exp [5];
    add_exp[0] = W_FETCH; add_exp[1] = W_DECODE; add_exp[2] = W_EXECR;
    add_exp[3] = W_ALUWB; add_exp[4] = W_FETCH;

    //         i   op     f3      a      bt cyc rw mw pcw ill mis be
    set_vec(0,  7'h33, 3'b000, 2'd0, 0, 4, 1, 0, 1, 0, 0, 4'b0000);
    set_vec(1,  7'h13, 3'b000, 2'd0, 0, 4, 1, 0, 1, 0, 0, 4'b0000);
    set_vec(2,  7'h03, 3'b010, 2'd0, 0, 5, 1, 0, 1, 0, 0, 4'b0000);
    set_vec(3,  7'h23, 3'b000, 2'd2, 0, 4, 0, 1, 1, 0, 0, 4'b0100);
    set_vec(4,  7'h23, 3'b001, 2'd2, 0, 4, 0, 1, 1, 0, 0, 4'b1100);
    set_vec(5,  7'h23, 3'b010, 2'd0, 0, 4, 0, 1, 1, 0, 0, 4'b1111);
    set_vec(6,  7'h23, 3'b001, 2'd1, 0, 4, 0, 0, 1, 0, 1, 4'b0000);
    set_vec(7,  7'h23, 3'b010, 2'd2, 0, 4, 0, 0, 1, 0, 1, 4'b0000);
    set_vec(8,  7'h63, 3'b000, 2'd0, 1, 3, 0, 0, 2, 0, 0, 4'b0000);
    set_vec(9,  7'h63, 3'b000, 2'd0, 0, 3, 0, 0, 1, 0, 0, 4'b0000);
    set_vec(10, 7'h6F, 3'b000, 2'd0, 0, 4, 1, 0, 2, 0, 0, 4'b0000);
    set_vec(11, 7'h67, 3'b000, 2'd0, 0, 5, 1, 0, 2, 0, 0, 4'b0000);
    set_vec(12, 7'h37, 3'b000, 2'd0, 0, 3, 1, 0, 1, 0, 0, 4'b0000);
    set_vec(13, 7'h17, 3'b000, 2'd0, 0, 4, 1, 0, 1, 0, 0, 4'b0000);
    set_vec(14, 7'h7F, 3'b000, 2'd0, 0, 3, 0, 0, 1, 1, 0, 4'b0000);
    set_vec(15, 7'h23, 3'b100, 2'd0, 0, 4, 0, 0, 1, 1, 0, 4'b0000);
    set_vec(16, 7'h23, 3'b011, 2'd0, 0, 4, 0, 0, 1, 1, 0, 4'b0000);
    set_vec(17, 7'h23, 3'b000, 2'd3, 0, 4, 0, 1, 1, 0, 0, 4'b1000);
    set_vec(18, 7'h03, 3'b010, 2'd1, 0, 5, 1, 0, 1, 0, 0, 4'b0000);

    reset = 1'b1; op = 7'h13; funct3 = 3'b000; addr_lo = '0;
    branch_taken = 1'b0; mem_ready = 1'b1;
    #2;
    check("reset_ctrl", {19'b0, ctrl_word()}, {19'b0, W_FETCH});
    check("reset_misc", {23'b0, illegal_instr, misaligned, byte_en, imm_src},
          32'b0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0; #1;
    check("post_reset_ctrl", {19'b0, ctrl_word()}, {19'b0, W_FETCH});

    op = 7'h33; funct3 = 3'b000; #1;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("add_cycle%0d", c + 1), {19'b0, ctrl_word()}, {19'b0, add_exp[c]});
      if (c < 4) begin
        @(negedge clk); #1;
      end
    end

    for (int i = 0; i < 18; i++) run_instr(i);

    op = 7'h23; funct3 = 3'b010; addr_lo = 2'd0;
    repeat (3) @(negedge clk);
    #1;
    check("memwrite_before_reset", {27'b0, mem_write, byte_en}, {27'b0, 1'b1, 4'b1111});
    reset = 1'b1; #1;
    check("memwrite_reset_async", {27'b0, mem_write, byte_en}, 32'b0);
    check("memwrite_reset_ctrl", {19'b0, ctrl_word()}, {19'b0, W_FETCH});
    @(negedge clk); reset = 1'b0; #1;
    check("memwrite_release_ctrl", {19'b0, ctrl_word()}, {19'b0, W_FETCH});
    run_instr(0);

`ifdef MEM_STALL_EN
    op = 7'h03; funct3 = 3'b010; addr_lo = 2'd0; mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    mem_ready = 1'b0; #1;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("stall_memread%0d", c), {30'b0, reg_write, adr_src}, 32'b01);
      @(negedge clk); #1;
    end
    check("stall_memread_hold", {30'b0, reg_write, adr_src}, 32'b01);
    mem_ready = 1'b1;
    @(negedge clk); #1;
    check("stall_memwb", {29'b0, reg_write, result_src}, {29'b0, 3'b101});
    @(negedge clk); #1;
    check("stall_back_fetch", {31'b0, ir_write}, 32'b1);
`else
    mem_ready = 1'b0;
    run_instr(18);
    mem_ready = 1'b1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
